// File: rtl/data_ram_pkg.sv
// Shared types and helpers for the handshaked data RAM.
package data_ram_pkg;

    // Transaction state: accept in StIdle, count down in StWait, hold response in StResp.
    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Constants for the default configuration (32-bit data, 1024 words).
    localparam int unsigned NB         = 4;
    localparam int unsigned LANE_IDX_W = 2;
    localparam int unsigned IDX_W      = 10;

    // Width of the counter that covers LATENCY-1 for the full legal latency range.
    localparam int unsigned CNT_W = 4;

    function automatic int unsigned lane_idx_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int unsigned idx_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Legal configurations only: whole byte lanes, power-of-2 depth of at least 2
    // words, and latency 1..8.
    function automatic bit params_ok(input int unsigned data_w,
                                     input int unsigned depth,
                                     input int unsigned latency);
        bit ok;
        ok = (data_w >= 8) && (data_w % 8 == 0);
        ok = ok && (depth >= 2) && ((depth & (depth - 1)) == 0);
        ok = ok && (latency >= 1) && (latency <= 8);
        return ok;
    endfunction

endpackage

// File: rtl/ram_lane.sv
// One byte lane: 8-bit x DEPTH bank with synchronous write and registered read.
module ram_lane #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem [DEPTH];

    // Write commits and read capture both happen on the accepting edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/data_ram_hs.sv
// Data memory with valid/ready request, programmable-latency held response,
// per-byte write enables and out-of-range error reporting.
module data_ram_hs
    import data_ram_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W/8-1:0]    req_sel,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_W-1:0]      resp_rdata,
    output logic                   resp_err
);

    localparam int unsigned LANES    = DATA_W / 8;
    localparam int unsigned LIDX_W   = lane_idx_w(DATA_W);
    localparam int unsigned IDX_BITS = idx_w(DEPTH);

    if (!params_ok(DATA_W, DEPTH, LATENCY)) begin : g_bad_params
        $error("data_ram_hs: illegal DATA_W/DEPTH/LATENCY combination");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q;
    logic               rd_ok_q;
    logic               accept;
    logic               in_range;
    logic [ADDR_W-1:0]  word_idx;
    logic [LANES-1:0]   lane_we;
    logic               lane_re;
    logic [DATA_W-1:0]  lane_rdata;

    // Word index and range check: any index bit at or above IDX_BITS means out of range.
    assign word_idx = req_addr >> LIDX_W;
    assign in_range = (word_idx >> IDX_BITS) == '0;

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_ready && req_valid;

    // Array strobes; gating by req_we keeps an X on req_sel during a read harmless.
    assign lane_re = accept && !req_we && in_range;
    assign lane_we = {LANES{accept && req_we && in_range}} & req_sel;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        ram_lane #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_BITS)
        ) u_lane (
            .clk   (clk),
            .we    (lane_we[i]),
            .re    (lane_re),
            .idx   (word_idx[IDX_BITS-1:0]),
            .wdata (req_wdata[8*i +: 8]),
            .rdata (lane_rdata[8*i +: 8])
        );
    end

    // Next-state and latency countdown.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, counter and response-kind registers; kind is latched on accept only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                err_q   <= !in_range;
                rd_ok_q <= !req_we && in_range;
            end
        end
    end

    // Lane read registers only change on a read accept, so the held response stays stable.
    assign resp_valid = (state_q == StResp);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && rd_ok_q) ? lane_rdata : '0;

endmodule

// File: doc/data_ram_hs.md
Name: data_ram_hs

Overview:
- Next-generation data memory for the CPU's MEM stage: parametrised width, depth and access latency, with per-byte write enables.
- Accepts one request at a time over a valid/ready handshake and returns an in-order response (read data or write ack) after a programmable latency.
- The response is held until the consumer accepts it.
- Out-of-range addresses are flagged with an error instead of aliasing.

Parameters:
- DATA_W, 32, data bus width in bits; a multiple of 8; byte lanes NB = DATA_W/8.
- ADDR_W, 32, byte-address width.
- DEPTH, 1024, words per lane; a power of 2.
- LATENCY, 1, cycles from the accepting edge to resp_valid; legal range 1..8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address; low log2(NB) bits are ignored for indexing.
- req_sel  in  NB  byte-lane write enables; bit i covers data[8i+7:8i].
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  address out of range.

Behaviour:
- Reset: synchronous on clk while rst=1.
  - State goes to IDLE; resp_valid=0, resp_rdata=0, resp_err=0; the latency counter is cleared.
  - req_ready=0 while rst=1.
  - Memory contents are not cleared.
  - Reset during WAIT or RESP abandons the transaction with no response. A write already committed at its accept edge stays committed.
- Index and range check:
  - Word index = req_addr >> log2(NB).
  - If the index >= DEPTH, the request is out of range: no array access, and the response carries resp_err=1 with resp_rdata=0.
- State machine IDLE / WAIT / RESP:
  - IDLE: req_ready=1. When req_valid=1, the request is accepted at that edge.
    - Write: enabled lanes commit at this edge; disabled lanes are untouched.
    - Read: the full word, all lanes regardless of req_sel, is captured at this edge.
    - Next state is RESP if LATENCY=1, otherwise WAIT with the counter = LATENCY-1.
  - WAIT: req_ready=0. The counter decrements each cycle; when it reaches 1, the next state is RESP.
  - RESP: resp_valid=1 with resp_rdata and resp_err stable. When resp_ready=1, the response is consumed at that edge, the next state is IDLE, and resp_valid drops.
- Latency: resp_valid rises exactly LATENCY cycles after the accepting edge.
  - Peak throughput is one transaction per LATENCY+1 cycles, because a new request is only accepted in IDLE.
- resp_rdata is 0 for writes and for errors.
- Holding response: while resp_valid=1 and resp_ready=0, all response outputs are held unchanged and request inputs are ignored.
- Read-after-write: a read accepted after a write's response has completed sees the written bytes merged with the unwritten lanes.
- req_valid outside IDLE is ignored; the requester must hold the request until req_ready=1.
- Unknown/X on req_sel during a read has no effect on memory.

Decomposition:
- Shared package data_ram_pkg:
  - state encoding (IDLE, WAIT, RESP)
  - helper constants NB, LANE_IDX_W = log2(NB), IDX_W = log2(DEPTH)
  - function checking legal LATENCY/DATA_W.
- Sub-module ram_lane: one 8-bit x DEPTH synchronous-write bank with a registered read, instantiated NB times via generate.
- The top level holds the FSM, counter, range check and response registers.

Test Plan:
- Reset, then write addr 0x10, sel 1111, wdata 0xDEADBEEF; read addr 0x10 with LATENCY=1 -> write ack (resp_err=0, rdata=0) 1 cycle after accept; read response rdata=0xDEADBEEF 1 cycle after accept.
- Partial write: write 0x11223344 to addr 0x20 with sel 1111, then 0xAABBCCDD with sel 0101; read addr 0x20 -> 0x11BB33DD.
- LATENCY=4, DEPTH=1024: read at addr 0x1000 (index 1024) -> resp_valid exactly 4 cycles after accept, resp_err=1, rdata=0, memory unchanged.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stay stable, req_ready=0, and a competing req_valid is ignored; resp_ready=1 -> back to IDLE the next cycle, req_ready=1.
- Reset mid-WAIT with LATENCY=3: assert rst one cycle after a read is accepted -> no resp_valid ever appears for it; all outputs read 0 after the reset edge; earlier writes are still readable.
- Parameter sweep DATA_W=64, NB=8: write 0x0123456789ABCDEF with sel 0xF0 over zeros at addr 0x8 -> read returns 0x0123456700000000.
